// File: rtl/mc_sequencer.sv
// Multi-cycle CPU control sequencer: steps FETCH/DECODE/EXEC/MEM/WB/HALT and
// emits the datapath and memory strobes plus a retired-instruction counter.
module mc_sequencer (
  input  logic        clk,
  input  logic        reset_cpu_n,
  input  logic        cpu_enable,
  input  logic [3:0]  opcode,
  input  logic [5:0]  func,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        wwd_strobe,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] num_inst
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] num_inst_q, num_inst_d;

  logic is_alu, is_lwd, is_swd, is_jmp, is_wwd, is_hlt;

  always_comb begin
    is_alu = (opcode == 4'd4) || (opcode == 4'd6) ||
             ((opcode == 4'd15) && (func == 6'd0));
    is_lwd = (opcode == 4'd7);
    is_swd = (opcode == 4'd8);
    is_jmp = (opcode == 4'd9);
    is_wwd = (opcode == 4'd15) && (func == 6'd28);
    is_hlt = (opcode == 4'd15) && (func == 6'd29);
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      state_q    <= S_FETCH;
      num_inst_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
    end
  end

  // Next state. A frozen sequencer keeps its state, so any ack seen while
  // cpu_enable is low is simply dropped and the request is re-issued later.
  always_comb begin
    state_d = state_q;
    if (cpu_enable) begin
      unique case (state_q)
        S_FETCH:  if (mem_ack) state_d = S_DECODE;
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (is_alu)               state_d = S_WB;
          else if (is_lwd || is_swd) state_d = S_MEM;
          else if (is_hlt)          state_d = S_HALT;
          else                      state_d = S_FETCH;
        end
        S_MEM:    if (mem_ack) state_d = is_swd ? S_FETCH : S_WB;
        S_WB:     state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path through the
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    wwd_strobe = 1'b0;
    // Reset gating lets an asserted reset kill an in-flight access at once.
    if (reset_cpu_n && cpu_enable) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
        end
        S_EXEC: begin
          if (is_wwd) begin
            wwd_strobe = 1'b1;
            pc_write   = 1'b1;
          end else if (!(is_alu || is_lwd || is_swd || is_hlt)) begin
            pc_write = 1'b1;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_sel  = 1'b1;
          mem_we   = is_swd;
          pc_write = mem_ack && is_swd;
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    num_inst_d = num_inst_q;
    if (pc_write || (cpu_enable && (state_q == S_EXEC) && is_hlt))
      num_inst_d = num_inst_q + 16'd1;
  end

  assign halted   = (state_q == S_HALT);
  assign state    = state_q;
  assign num_inst = num_inst_q;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 reset_cpu_n  input  1  asynchronous, active-low reset.
REQ-003 cpu_enable  input  1  1 = sequencer advances; 0 = freeze.
REQ-004 opcode  input  4  instruction-register bits [15:12].
REQ-005 func  input  6  instruction-register bits [5:0].
REQ-006 mem_ack  input  1  memory completion, valid in the cycle it is high.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  1 = write access.
REQ-009 mem_sel  output  1  address source: 0 = PC (instruction), 1 = ALU result (data).
REQ-010 ir_write  output  1  load instruction register.
REQ-011 pc_write  output  1  update PC (next PC or jump target, chosen by datapath).
REQ-012 reg_write  output  1  register-file write strobe.
REQ-013 wwd_strobe  output  1  capture register value onto output_port.
REQ-014 halted  output  1  1 while in HALT.
REQ-015 state  output  3  current state encoding.
REQ-016 num_inst  output  16  retired-instruction count.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL return to FETCH on the next edge.
REQ-018 Strobe outputs SHALL be combinational from state, opcode, func and mem_ack, and SHALL all be forced to 0 when cpu_enable=0.
REQ-019 FETCH: mem_req=1, mem_sel=0, mem_we=0; when mem_ack=1, ir_write=1 for that cycle, and the next state is DECODE; otherwise FETCH holds, with mem_req kept high.
REQ-020 DECODE SHALL last exactly one cycle, then enter EXEC.
REQ-021 EXEC by instruction:
- ADI (4), LHI (6), ADD (15/0): next state WB.
- LWD (7), SWD (8): next state MEM.
- JMP (9): pc_write=1, next state FETCH.
- WWD (15/28): wwd_strobe=1, pc_write=1, next state FETCH.
- HLT (15/29): next state HALT.
- Any other encoding: pc_write=1, next state FETCH (treated as NOP).
REQ-022 MEM: mem_req=1, mem_sel=1, mem_we=1 only for SWD.
- On mem_ack with LWD: next state WB.
- On mem_ack with SWD: pc_write=1, next state FETCH.
- Without mem_ack: hold in MEM.
REQ-023 WB: reg_write=1, pc_write=1, next state FETCH.
REQ-024 HALT: halted=1 and all strobes 0; the sequencer leaves HALT only via reset.
REQ-025 mem_ack SHALL be ignored in DECODE, EXEC, WB and HALT.
REQ-026 num_inst SHALL increment by 1 on each edge where pc_write=1 or where EXEC enters HALT, and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 With cpu_enable=0: state and num_inst hold; mem_ack arriving in that cycle is discarded; the outstanding request is re-issued once cpu_enable returns to 1.
REQ-028 Latencies with zero-wait memory (mem_ack in the first request cycle):
- ALU/LHI: 4 cycles.
- JMP/WWD/NOP: 3 cycles.
- LWD: 5 cycles.
- SWD: 4 cycles.

Reset
REQ-029 While reset_cpu_n=0: state=FETCH, num_inst=0, halted=0, and all strobes 0 regardless of the clock.
REQ-030 Reset asserted mid-access SHALL abort it immediately (mem_req drops in the same cycle with no write strobe); after release, the first cycle is FETCH with mem_req=1 (if cpu_enable=1).

Verification
REQ-031 Reset release, cpu_enable=1, mem_ack tied 1, opcode=6 (LHI) -> states 0,1,2,4 repeating; reg_write and pc_write high in the WB cycle; num_inst=3 after 12 cycles.
REQ-032 FETCH with mem_ack low for 5 cycles then high -> mem_req high for 6 cycles, one ir_write pulse in cycle 6, DECODE in cycle 7.
REQ-033 opcode=7 (LWD), mem_ack 1 -> sequence 0,1,2,3,4; mem_sel=1 only in MEM; mem_we never 1. opcode=8 (SWD) -> mem_we=1 in MEM and no WB state.
REQ-034 opcode=15, func=29 -> HALT; halted=1 and num_inst frozen for 20 cycles; reset_cpu_n pulsed low -> state=0, num_inst=0 asynchronously.
REQ-035 cpu_enable dropped for 3 cycles while in MEM with mem_ack=1 -> state stays 3, all strobes 0; on re-enable, the access completes in one cycle.
REQ-036 num_inst preloaded to 0xFFFF via 65535 JMPs, then one more JMP -> num_inst=0x0000.
